popcount_accumulator: RTL and testbench
=======================================

Name: popcount_accumulator

Overview:
Downstream consumer of the 5-input ones-counter stage. It accepts a framed stream of 5-bit words over a valid/ready handshake and reduces each word to a 3-bit ones count. It accumulates the counts over the frame and presents the frame's total ones count, beat count and overflow flag on a held, handshaked result port. Each frame feeds one result to the next block in the accumulator chain.

Parameters:
ACC_W, 8, width of the sum and beat-count accumulators; legal range 4..16.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  in_data / in_last are valid.
in_ready  output  1  block accepts a beat this cycle.
in_data  input  5  word whose set bits are counted.
in_last  input  1  marks the final beat of a frame.
out_valid  output  1  result registers hold a completed frame.
out_ready  input  1  downstream consumes the result.
out_sum  output  ACC_W  total ones in the frame, saturating.
out_beats  output  ACC_W  beats in the frame, saturating.
out_ovf  output  1  out_sum or out_beats saturated during the frame.

Behaviour:
- Clock is clk. Reset is asynchronous, active-low rst_n. Every register is cleared on reset; no synchronous reset.
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_beats=0, out_ovf=0. Internal acc, beats, ovf, s1_valid and s1_last are all 0.
- Accept rule: a beat is accepted on a rising edge where in_valid && in_ready.
- in_ready = !out_valid && !(s1_valid && s1_last). It is combinational from registers only, never from in_valid or out_ready.
- Stage 1, registered on accept:
  - s1_cnt is counter_5to3(in_data), range 0..5. Code 3'b111 cannot occur.
  - s1_last is in_last, and s1_valid is set to 1.
  - With no accept, s1_valid is set to 0.
- Stage 2, on each edge where s1_valid=1:
  - Compute nsum = acc + s1_cnt in ACC_W+1 bits. If bit ACC_W is set, the sum is clamped to 2^ACC_W-1 and ovf is set.
  - Compute nbeats = beats + 1 with the same clamp and ovf rule.
  - If s1_last=0: acc <= clamped nsum, beats <= clamped nbeats.
  - If s1_last=1: out_sum, out_beats and out_ovf are loaded with the clamped values and the final ovf, and out_valid <= 1. acc, beats and ovf are cleared to 0 for the next frame.
- Latency: with the last beat accepted at edge N, out_valid rises after edge N+1.
- Output hold: while out_valid && !out_ready, out_sum, out_beats and out_ovf are stable and in_ready=0. in_valid is ignored, and a mid-frame stall is legal.
- Output release: at the edge where out_valid && out_ready, out_valid <= 0. in_ready returns to 1 in the following cycle.
- Frame boundary: the beat after in_last begins a new frame from zero. A single-beat frame is legal; there are no zero-beat frames.
- Throughput: one beat per cycle inside a frame. There is a minimum 2-cycle input bubble after each last beat, plus any backpressure time.
- Reset mid-frame or mid-hold: the partial frame and any held result are discarded, and all outputs return to their reset values immediately.
- Input word values are unconstrained; all 32 codes are legal.

Decomposition:
- Package popacc_pkg holds:
  - CNT_W = 3 (count width).
  - CNT_MAX = 5 (maximum count).
  - IN_W = 5 (input word width).
  - The saturating-add helper function sat_add(a, b, w), returning the clamped value and a carry flag.
- One sub-module: an instance of counter_5to3 drives s1_cnt's D input. There is no other hierarchy.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> in_ready=1, out_valid=0, out_sum=0, out_beats=0, out_ovf=0. Release, then toggle inputs without in_last -> no out_valid.
- Basic frame (ACC_W=8): beats 5'b11111, 5'b00011, 5'b10000+last on consecutive cycles, out_ready=1 -> out_valid for exactly 1 cycle, 2 edges after the last-beat accept, with out_sum=8, out_beats=3, out_ovf=0.
- Backpressure: same frame with out_ready=0 for 4 cycles -> out_sum=8 stable and in_ready=0 throughout, even with in_valid=1. After out_ready=1 handshake, in_ready=1 on the next cycle and the next frame 5'b01010+last gives out_sum=2, out_beats=1.
- Saturation (ACC_W=4): four beats of 5'b11111, the 4th with last -> out_sum=15, out_beats=4, out_ovf=1. The next frame 5'b00001+last -> out_sum=1, out_ovf=0, showing the sticky flag was cleared.
- Single-beat and zero data: 5'b00000+last -> out_sum=0, out_beats=1, out_ovf=0.
- Reset mid-frame: accept 5'b11100, 5'b00111, then pulse rst_n low for 1 cycle. Then send 5'b00001+last -> out_sum=1, out_beats=1, out_ovf=0.

Source files
------------

// File: rtl/popcount_accumulator_pkg.sv
// Shared constants and helpers for the popcount accumulator.
// Holds count widths and the saturating-add helper.
package popacc_pkg;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = 5;
  localparam int IN_W    = 5;
  localparam int MAXW    = 16;

  typedef struct packed {
    logic [MAXW-1:0] val;
    logic            carry;
  } sat_t;

  // Adds a and b and clamps the result to the largest w-bit value.
  // carry is set when the clamp takes effect.
  function automatic sat_t sat_add(
    input logic [MAXW-1:0] a,
    input logic [MAXW-1:0] b,
    input int unsigned     w
  );
    logic [MAXW:0] s;
    logic [MAXW:0] lim;
    sat_t          r;
    s       = {1'b0, a} + {1'b0, b};
    lim     = ((MAXW+1)'(1) << w) - (MAXW+1)'(1);
    r.carry = (s > lim);
    r.val   = r.carry ? lim[MAXW-1:0] : s[MAXW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/popcount_accumulator_counter_5to3.sv
// 5-input ones counter built from two full adders and a half adder.
// Ports: i_data (5-bit word), o_cnt (3-bit ones count, 0..5).
module counter_5to3
  import popacc_pkg::*;
(
  input  logic [IN_W-1:0]  i_data,
  output logic [CNT_W-1:0] o_cnt
);

  logic w_s1;
  logic w_c1;
  logic w_s2;
  logic w_c2;

  assign w_s1 = i_data[0] ^ i_data[1] ^ i_data[2];
  assign w_c1 = (i_data[0] & i_data[1])
              | (i_data[0] & i_data[2])
              | (i_data[1] & i_data[2]);

  assign w_s2 = i_data[3] ^ i_data[4] ^ w_s1;
  assign w_c2 = (i_data[3] & i_data[4])
              | (i_data[3] & w_s1)
              | (i_data[4] & w_s1);

  // Both carries weigh 2; combining them gives bits 1 and 2.
  assign o_cnt[0] = w_s2;
  assign o_cnt[1] = w_c1 ^ w_c2;
  assign o_cnt[2] = w_c1 & w_c2;

endmodule

// File: rtl/popcount_accumulator.sv
// Frames 5-bit words, sums their ones counts and beats per frame.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_last, out_valid/out_ready/out_sum/out_beats/out_ovf.
module popcount_accumulator
  import popacc_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [ACC_W-1:0] out_beats,
  output logic             out_ovf
);

  logic [CNT_W-1:0] w_cnt;
  logic             w_accept;
  sat_t             w_nsum;
  sat_t             w_nbeats;
  logic             w_novf;
  logic             w_unused;

  logic             r_s1_valid;
  logic             r_s1_last;
  logic [CNT_W-1:0] r_s1_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_beats;
  logic             r_ovf;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [ACC_W-1:0] r_out_beats;
  logic             r_out_ovf;

  counter_5to3 u_cnt (
    .i_data (in_data),
    .o_cnt  (w_cnt)
  );

  // Stall while a result is held or a last beat is still in stage 1,
  // so a new frame never races the result load.
  assign in_ready = !r_out_valid && !(r_s1_valid && r_s1_last);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_nsum   = sat_add(MAXW'(r_acc), MAXW'(r_s1_cnt), ACC_W);
    w_nbeats = sat_add(MAXW'(r_beats), MAXW'(1), ACC_W);
    w_novf   = r_ovf | w_nsum.carry | w_nbeats.carry;
  end

  // Upper helper bits stay zero for ACC_W below MAXW.
  assign w_unused = &{1'b0, w_nsum.val, w_nbeats.val};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_cnt   <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_last  <= in_last;
      r_s1_cnt   <= w_cnt;
    end else begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_beats <= '0;
      r_ovf   <= 1'b0;
    end else if (r_s1_valid) begin
      if (r_s1_last) begin
        r_acc   <= '0;
        r_beats <= '0;
        r_ovf   <= 1'b0;
      end else begin
        r_acc   <= w_nsum.val[ACC_W-1:0];
        r_beats <= w_nbeats.val[ACC_W-1:0];
        r_ovf   <= w_novf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_beats <= '0;
      r_out_ovf   <= 1'b0;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end else if (r_s1_valid && r_s1_last) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_nsum.val[ACC_W-1:0];
      r_out_beats <= w_nbeats.val[ACC_W-1:0];
      r_out_ovf   <= w_novf;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_beats = r_out_beats;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_popcount_accumulator.sv
// Bench for popcount_accumulator at ACC_W=8 and ACC_W=4 side by side.
// Table vectors, hand sequences and random frames against a frame model.
module tb_popcount_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_last;
  logic       out_ready;
  logic       in_ready;
  logic       in_ready4;
  logic       ov8;
  logic       ov4;
  logic [7:0] s8;
  logic [7:0] b8;
  logic [3:0] s4;
  logic [3:0] b4;
  logic       of8;
  logic       of4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  popcount_accumulator #(.ACC_W(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (ov8),
    .out_ready (out_ready),
    .out_sum   (s8),
    .out_beats (b8),
    .out_ovf   (of8)
  );

  popcount_accumulator #(.ACC_W(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (ov4),
    .out_ready (out_ready),
    .out_sum   (s4),
    .out_beats (b4),
    .out_ovf   (of4)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int s8;
    int b8;
    int o8;
    int s4;
    int b4;
    int o4;
  } res_t;

  function automatic res_t mk(input int ones, input int n);
    res_t r;
    r.s8 = (ones > 255) ? 255 : ones;
    r.b8 = (n > 255) ? 255 : n;
    r.o8 = (ones > 255 || n > 255) ? 1 : 0;
    r.s4 = (ones > 15) ? 15 : ones;
    r.b4 = (n > 15) ? 15 : n;
    r.o4 = (ones > 15 || n > 15) ? 1 : 0;
    return r;
  endfunction

  // Frame model: tallies accepted words and queues the frame result.
  res_t expq[$];
  int   fr_ones  = 0;
  int   fr_beats = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      fr_ones  = 0;
      fr_beats = 0;
      expq.delete();
    end else begin
      if (ov8 || ov4) begin
        chk("valid8", ov8, 1);
        chk("valid4", ov4, 1);
        chk("hold_in_ready", in_ready, 0);
        if (expq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("m_sum8", s8, expq[0].s8);
          chk("m_beats8", b8, expq[0].b8);
          chk("m_ovf8", of8, expq[0].o8);
          chk("m_sum4", s4, expq[0].s4);
          chk("m_beats4", b4, expq[0].b4);
          chk("m_ovf4", of4, expq[0].o4);
          if (out_ready) void'(expq.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        fr_ones  += $countones(in_data);
        fr_beats += 1;
        if (in_last) begin
          expq.push_back(mk(fr_ones, fr_beats));
          fr_ones  = 0;
          fr_beats = 0;
        end
      end
    end
  end

  task automatic send_beat(input logic [4:0] d, input logic l);
    int k;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov8 && lat < 10);
  endtask

  typedef struct {
    int              n;
    logic [3:0][4:0] w;
    int              hold;
    int              s8;
    int              b8;
    int              o8;
    int              s4;
    int              b4;
    int              o4;
  } vec_t;

  vec_t tbl[6];
  int   lat;
  bit   done;

  initial begin
    tbl[0] = '{3, {5'b0, 5'b10000, 5'b00011, 5'b11111}, 0, 8, 3, 0, 8, 3, 0};
    tbl[1] = '{3, {5'b0, 5'b10000, 5'b00011, 5'b11111}, 4, 8, 3, 0, 8, 3, 0};
    tbl[2] = '{1, {5'b0, 5'b0, 5'b0, 5'b01010}, 0, 2, 1, 0, 2, 1, 0};
    tbl[3] = '{4, {5'b11111, 5'b11111, 5'b11111, 5'b11111}, 0,
               20, 4, 0, 15, 4, 1};
    tbl[4] = '{1, {5'b0, 5'b0, 5'b0, 5'b00001}, 0, 1, 1, 0, 1, 1, 0};
    tbl[5] = '{1, {5'b0, 5'b0, 5'b0, 5'b00000}, 0, 0, 1, 0, 0, 1, 0};

    // Reset with in_valid high.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 5'b11111;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", ov8, 0);
    chk("rst_sum", s8, 0);
    chk("rst_beats", b8, 0);
    chk("rst_ovf", of8, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      in_valid = i[0];
      in_data  = 5'($urandom);
      in_last  = 1'b0;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_last_no_valid", ov8, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table vectors.
    for (int i = 0; i < 6; i++) begin
      out_ready = (tbl[i].hold == 0);
      for (int b = 0; b < tbl[i].n; b++)
        send_beat(tbl[i].w[b], b == tbl[i].n - 1);
      wait_result(lat);
      chk("latency", lat, 2);
      chk("t_sum8", s8, tbl[i].s8);
      chk("t_beats8", b8, tbl[i].b8);
      chk("t_ovf8", of8, tbl[i].o8);
      chk("t_sum4", s4, tbl[i].s4);
      chk("t_beats4", b4, tbl[i].b4);
      chk("t_ovf4", of4, tbl[i].o4);
      if (tbl[i].hold > 0) begin
        #1;
        in_valid = 1'b1;
        in_data  = 5'b11111;
        in_last  = 1'b1;
        repeat (tbl[i].hold) begin
          @(negedge clk);
          chk("hold_valid", ov8, 1);
          chk("hold_sum", s8, tbl[i].s8);
          chk("hold_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        @(negedge clk);
      end
      @(negedge clk);
      chk("one_cycle_valid", ov8, 0);
      chk("ready_back", in_ready, 1);
      @(posedge clk);
      #1;
    end

    // Reset in the middle of a frame.
    send_beat(5'b11100, 1'b0);
    send_beat(5'b00111, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ov8, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_beat(5'b00001, 1'b1);
    wait_result(lat);
    chk("after_rst_sum", s8, 1);
    chk("after_rst_beats", b8, 1);
    chk("after_rst_ovf", of8, 0);
    @(posedge clk);
    #1;

    // Random frames with random backpressure and gaps.
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 30; f++) begin
          int n;
          bit full;
          full = (f == 3 || f == 7);
          n = (f == 7) ? 260 : (f == 3) ? 20 : $urandom_range(1, 20);
          for (int b = 0; b < n; b++) begin
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk);
              #1;
            end
            send_beat(full ? 5'b11111 : 5'($urandom), b == n - 1);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    lat = 0;
    while (expq.size() != 0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("drain", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
